// File: rtl/cdb_arbiter_pkg.sv
// Shared defaults, functional-unit indices and the broadcast bus type for the CDB arbiter.
package cdb_pkg;

    localparam int unsigned CDB_DATA_WIDTH = 32;
    localparam int unsigned CDB_TAG_WIDTH  = 7;
    localparam int unsigned CDB_NUM_REQ    = 4;

    localparam int unsigned UNIT_ALU = 0;
    localparam int unsigned UNIT_MUL = 1;
    localparam int unsigned UNIT_DIV = 2;
    localparam int unsigned UNIT_LSU = 3;

    typedef struct packed {
        logic                      valid;
        logic [CDB_TAG_WIDTH-1:0]  tag;
        logic [CDB_DATA_WIDTH-1:0] data;
        logic                      branch;
        logic                      branch_taken;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Request arbiter for the CDB: round-robin with a one-hot pointer when CDB_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with the lowest index winning. Requires N >= 2.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam logic [N-1:0] ONE = N'(1);

`ifdef CDB_ROUND_ROBIN_EN
    logic [N-1:0] ptr;
    logic [N-1:0] req_hi;
    logic [N-1:0] grant_hi;
    logic [N-1:0] grant_lo;

    // Requests at or above the pointer take precedence; otherwise wrap to the lowest index.
    always_comb begin
        req_hi   = req & ~(ptr - ONE);
        grant_hi = req_hi & (~req_hi + ONE);
        grant_lo = req & (~req + ONE);
        grant    = '0;
        if (en) begin
            grant = (req_hi != '0) ? grant_hi : grant_lo;
        end
    end

    // grant is already zero under reset or flush, so the pointer holds then.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= ONE;
        end else if (grant != '0) begin
            ptr <= {grant[N-2:0], grant[N-1]};
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{clk, reset};

    always_comb begin
        grant = '0;
        if (en) begin
            grant = req & (~req + ONE);
        end
    end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one functional-unit result per cycle and broadcasts it
// one cycle later. Define CDB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CDB_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = CDB_TAG_WIDTH,
    parameter int unsigned NUM_REQ    = CDB_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_branch,
    input  logic [NUM_REQ-1:0]            req_branch_taken,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          CDB_valid,
    output logic [TAG_WIDTH-1:0]          CDB_tag,
    output logic [DATA_WIDTH-1:0]         CDB_data,
    output logic                          CDB_branch,
    output logic                          CDB_branch_taken
);

    logic                  en;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_branch;
    logic                  sel_taken;

    assign en = ~reset & ~flush;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req   (req),
        .grant (grant)
    );

    // grant is one-hot or zero, so an AND-OR mux is sufficient.
    always_comb begin
        sel_tag    = '0;
        sel_data   = '0;
        sel_branch = 1'b0;
        sel_taken  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_tag    = sel_tag    | req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                sel_data   = sel_data   | req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_branch = sel_branch | req_branch[i];
                sel_taken  = sel_taken  | req_branch_taken[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            CDB_valid        <= 1'b0;
            CDB_tag          <= '0;
            CDB_data         <= '0;
            CDB_branch       <= 1'b0;
            CDB_branch_taken <= 1'b0;
        end else if (grant != '0) begin
            CDB_valid        <= 1'b1;
            CDB_tag          <= sel_tag;
            CDB_data         <= sel_data;
            CDB_branch       <= sel_branch;
            CDB_branch_taken <= sel_taken;
        end else begin
            CDB_valid        <= 1'b0;
            CDB_branch       <= 1'b0;
            CDB_branch_taken <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter; expectations adapt to CDB_ROUND_ROBIN_EN.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    typedef struct {
        logic       rst;
        logic       fl;
        logic [3:0] r;
        logic [3:0] br;
        logic [3:0] bt;
        logic [3:0] eg;
        string      name;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset, flush;
    logic [3:0]   req, req_branch, req_branch_taken, grant;
    logic [27:0]  req_tag;
    logic [127:0] req_data;
    logic         CDB_valid, CDB_branch, CDB_branch_taken;
    logic [6:0]   CDB_tag;
    logic [31:0]  CDB_data;

    cdb_bus_t sb[$];
    cdb_bus_t prev;
    vec_t     vecs[$];
    int       checks = 0;
    int       fails  = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(7), .NUM_REQ(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .req              (req),
        .req_tag          (req_tag),
        .req_data         (req_data),
        .req_branch       (req_branch),
        .req_branch_taken (req_branch_taken),
        .grant            (grant),
        .CDB_valid        (CDB_valid),
        .CDB_tag          (CDB_tag),
        .CDB_data         (CDB_data),
        .CDB_branch       (CDB_branch),
        .CDB_branch_taken (CDB_branch_taken)
    );

    task automatic cycle(input logic rst, input logic fl, input logic [3:0] r,
                         input logic [3:0] br, input logic [3:0] bt, input logic [3:0] eg,
                         input logic [27:0] tg, input logic [127:0] dt, input string name);
        cdb_bus_t got, exp, nxt;
        reset = rst; flush = fl; req = r; req_branch = br; req_branch_taken = bt;
        req_tag = tg; req_data = dt;
        @(negedge clk);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            got.valid = CDB_valid; got.tag = CDB_tag; got.data = CDB_data;
            got.branch = CDB_branch; got.branch_taken = CDB_branch_taken;
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s cdb: got v=%b tag=%h data=%h br=%b tk=%b, expected v=%b tag=%h data=%h br=%b tk=%b",
                         name, got.valid, got.tag, got.data, got.branch, got.branch_taken,
                         exp.valid, exp.tag, exp.data, exp.branch, exp.branch_taken);
            end
        end
        checks++;
        if (grant !== eg) begin
            fails++;
            $display("FAIL %s grant: got %b expected %b", name, grant, eg);
        end
        nxt = prev;
        if (rst) begin
            nxt = '0;
        end else if (eg != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (eg[k]) begin
                    nxt.valid = 1'b1;
                    nxt.tag = tg[k*7 +: 7];
                    nxt.data = dt[k*32 +: 32];
                    nxt.branch = br[k];
                    nxt.branch_taken = bt[k];
                end
            end
        end else begin
            nxt.valid = 1'b0;
            nxt.branch = 1'b0;
            nxt.branch_taken = 1'b0;
        end
        prev = nxt;
        sb.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vecs();
        logic [27:0]  tg;
        logic [127:0] dt;
        for (int i = 0; i < vecs.size(); i++) begin
            tg = 28'($urandom);
            dt = {$urandom, $urandom, $urandom, $urandom};
            cycle(vecs[i].rst, vecs[i].fl, vecs[i].r, vecs[i].br, vecs[i].bt, vecs[i].eg,
                  tg, dt, vecs[i].name);
        end
        vecs.delete();
    endtask

    initial begin
        logic [3:0] div_bit;
        prev = '0;
        div_bit = 4'b0001 << UNIT_DIV;

        // Reset, then idle requests.
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, "reset"});
        vecs.push_back('{1'b1, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, "reset"});
        for (int i = 0; i < 3; i++)
            vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, "idle"});
        run_vecs();

        cycle(1'b0, 1'b0, 4'b0001, 4'b0, 4'b0, 4'b0001, 28'h05, 128'hDEADBEEF, "single");
        cycle(1'b0, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, 28'h0, 128'h0, "single_bcast");
        cycle(1'b0, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, 28'h0, 128'h0, "hold");

        vecs.push_back('{1'b1, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, "reset_ptr"});
`ifdef CDB_ROUND_ROBIN_EN
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0, 4'b0, 4'b0001, "rr_all_0"});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0, 4'b0, 4'b0010, "rr_all_1"});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0, 4'b0, 4'b0100, "rr_all_2"});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0, 4'b0, 4'b1000, "rr_all_3"});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0, 4'b0, 4'b0001, "rr_wrap"});
        vecs.push_back('{1'b0, 1'b0, 4'b1010, 4'b0, 4'b0, 4'b0010, "rr_1010_a"});
        vecs.push_back('{1'b0, 1'b0, 4'b1010, 4'b0, 4'b0, 4'b1000, "rr_1010_b"});
        vecs.push_back('{1'b0, 1'b0, 4'b1010, 4'b0, 4'b0, 4'b0010, "rr_1010_c"});
        vecs.push_back('{1'b0, 1'b0, 4'b1010, 4'b0, 4'b0, 4'b1000, "rr_1010_d"});
`else
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0, 4'b0, 4'b0001, "fp_all"});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{1'b0, 1'b0, 4'b1010, 4'b0, 4'b0, 4'b0010, "fp_1010"});
`endif
        vecs.push_back('{1'b0, 1'b1, 4'b0100, 4'b0, 4'b0, 4'b0000, "flush_0100"});
        vecs.push_back('{1'b0, 1'b1, 4'b1111, 4'b0, 4'b0, 4'b0000, "flush_1111"});
        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0, 4'b0, 4'b0001, "after_flush_ptr"});
        vecs.push_back('{1'b0, 1'b0, 4'b0100, 4'b0, 4'b0, 4'b0100, "after_flush_req"});
        run_vecs();

        // Branch broadcast pending when reset arrives: it is shown once, then cleared.
        cycle(1'b0, 1'b0, div_bit, div_bit, div_bit, div_bit, 28'h1ABCDEF,
              {$urandom, $urandom, $urandom, $urandom}, "div_branch");
        cycle(1'b1, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, 28'h0, 128'h0, "reset_pending");

        vecs.push_back('{1'b0, 1'b0, 4'b1111, 4'b0, 4'b0, 4'b0001, "ptr_after_reset"});
        vecs.push_back('{1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, "mul_branch_nt"});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, "idle_bcast"});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, "flags_clear"});
        vecs.push_back('{1'b0, 1'b0, 4'b0000, 4'b0, 4'b0, 4'b0000, "drain"});
        run_vecs();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
